type_rule_cfg: RTL and testbench

TYPE_RULE_CFG -- requirements
Module: type_rule_cfg

---
 rtl/type_rule_cfg.sv | 187 ++++++++++++++++++
 tb/tb_type_rule_cfg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/type_rule_cfg.sv
// Type-rule configuration loader.
// Accepts a stream of header/payload beats, assembles flattened type rules and
// issues single-cycle write strobes to a downstream rule lookup table.
module type_rule_cfg #(
    parameter int RULE_NUM   = 8,
    parameter int RULE_WIDTH = 192,
    parameter int CFG_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cfg_valid,
    input  logic [CFG_WIDTH-1:0]  i_cfg_data,
    output logic                  o_cfg_ready,
    output logic [RULE_NUM-1:0]   o_rule_wren,
    output logic [RULE_WIDTH-1:0] o_type_rule,
    output logic                  o_done,
    output logic                  o_err,
    output logic [15:0]           o_commit_cnt
);

    localparam int NWORDS = (RULE_WIDTH + CFG_WIDTH - 1) / CFG_WIDTH;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int ASM_W  = NWORDS * CFG_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NWORDS - 1);

    localparam logic [3:0] OP_WRITE     = 4'd1;
    localparam logic [3:0] OP_CLEAR     = 4'd2;
    localparam logic [3:0] OP_CLEAR_ALL = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [7:0]            idx_q, idx_d;
    logic                  run_q;
    logic [ASM_W-1:0]      asm_q, asm_next;
    logic                  asm_wr;
    logic [RULE_NUM-1:0]   wren_d;
    logic [RULE_WIDTH-1:0] rule_d;
    logic                  done_d, err_d;

    logic                  fire;
    logic [3:0]            hdr_op;
    logic [7:0]            hdr_idx;
    logic                  hdr_idx_ok;

    // One-hot strobe for a rule slot; indices outside the table give no bit.
    function automatic logic [RULE_NUM-1:0] slot_onehot(input logic [7:0] idx);
        logic [RULE_NUM-1:0] v;
        v = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            v[i] = (i == int'(idx));
        end
        return v;
    endfunction

    assign o_cfg_ready = run_q && (state_q != S_COMMIT);
    assign fire        = i_cfg_valid && o_cfg_ready;
    assign hdr_op      = i_cfg_data[31:28];
    assign hdr_idx     = i_cfg_data[15:8];
    assign hdr_idx_ok  = (int'(hdr_idx) < RULE_NUM);

    // Assembly view with the incoming beat merged into its word slot.
    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < NWORDS; k++) begin
            if (beat_q == CNT_W'(k)) begin
                asm_next[k*CFG_WIDTH +: CFG_WIDTH] = i_cfg_data;
            end
        end
    end

    // Next-state decode; strobe, rule and pulses are computed here and
    // registered so they appear in the cycle the FSM sits in COMMIT.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        asm_wr  = 1'b0;
        wren_d  = '0;
        rule_d  = o_type_rule;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    case (hdr_op)
                        OP_WRITE: begin
                            idx_d   = hdr_idx;
                            beat_d  = '0;
                            state_d = hdr_idx_ok ? S_LOAD : S_DRAIN;
                        end
                        OP_CLEAR: begin
                            if (hdr_idx_ok) begin
                                state_d = S_COMMIT;
                                wren_d  = slot_onehot(hdr_idx);
                                rule_d  = '0;
                                done_d  = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLEAR_ALL: begin
                            state_d = S_COMMIT;
                            wren_d  = '1;
                            rule_d  = '0;
                            done_d  = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                if (fire) begin
                    asm_wr = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_COMMIT;
                        wren_d  = slot_onehot(idx_q);
                        rule_d  = asm_next[RULE_WIDTH-1:0];
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (fire) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            idx_q       <= '0;
            run_q       <= 1'b0;
            o_rule_wren <= '0;
            o_type_rule <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            idx_q       <= idx_d;
            run_q       <= 1'b1;
            o_rule_wren <= wren_d;
            o_type_rule <= rule_d;
            o_done      <= done_d;
            o_err       <= err_d;
        end
    end

    // Payload assembly register; a partial rule is never exposed, so no reset.
    always_ff @(posedge i_clk) begin
        if (asm_wr) begin
            asm_q <= asm_next;
        end
    end

    // Saturating count of commits, bumped at the end of each COMMIT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_commit_cnt <= '0;
        end else if (state_q == S_COMMIT && o_commit_cnt != 16'hFFFF) begin
            o_commit_cnt <= o_commit_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_type_rule_cfg.sv
// Testbench for type_rule_cfg: directed scenarios plus randomized commands,
// checked against a command-level reference model.
module tb_type_rule_cfg;

    localparam int RULE_NUM   = 8;
    localparam int RULE_WIDTH = 192;
    localparam int CFG_WIDTH  = 32;
    localparam int NWORDS     = 6;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  valid = 1'b0;
    logic [CFG_WIDTH-1:0]  data = '0;
    logic                  ready;
    logic [RULE_NUM-1:0]   wren;
    logic [RULE_WIDTH-1:0] rule;
    logic                  done;
    logic                  err;
    logic [15:0]           cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0]           pay [NWORDS];
    logic [RULE_WIDTH-1:0] m_rule;
    int                    m_cnt;
    logic [RULE_WIDTH-1:0] saved_rule;

    type_rule_cfg #(
        .RULE_NUM   (RULE_NUM),
        .RULE_WIDTH (RULE_WIDTH),
        .CFG_WIDTH  (CFG_WIDTH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (valid),
        .i_cfg_data   (data),
        .o_cfg_ready  (ready),
        .o_rule_wren  (wren),
        .o_type_rule  (rule),
        .o_done       (done),
        .o_err        (err),
        .o_commit_cnt (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Sends one command (header plus any payload) and checks the outcome
    // against the command-level model. stall_at < 0 means no stall.
    task automatic run_cmd(input logic [31:0] hdr, input int stall_at, input int stall_len);
        logic [3:0]            op;
        logic [7:0]            idx;
        int                    np;
        logic [RULE_NUM-1:0]   e_wren;
        logic [RULE_WIDTH-1:0] e_rule;
        logic                  e_done;
        logic                  e_err;
        op     = hdr[31:28];
        idx    = hdr[15:8];
        np     = (op == 4'd1) ? NWORDS : 0;
        e_wren = '0;
        e_rule = m_rule;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (op == 4'd1) begin
            if (int'(idx) < RULE_NUM) begin
                e_wren = RULE_NUM'(1 << idx);
                e_rule = '0;
                for (int k = 0; k < NWORDS; k++) e_rule[k*32 +: 32] = pay[k];
                e_done = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end else if (op == 4'd2) begin
            if (int'(idx) < RULE_NUM) begin
                e_wren = RULE_NUM'(1 << idx);
                e_rule = '0;
                e_done = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end else if (op == 4'd3) begin
            e_wren = '1;
            e_rule = '0;
            e_done = 1'b1;
        end else begin
            e_err = 1'b1;
        end

        data  = hdr;
        valid = 1'b1;
        step();
        for (int k = 0; k < np; k++) begin
            chk("busy_quiet", 256'({wren, done, err}), 256'(0));
            chk("busy_ready", 256'(ready), 256'(1));
            if (k == stall_at) begin
                valid = 1'b0;
                data  = $urandom;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk("stall_quiet", 256'({wren, done, err}), 256'(0));
                    chk("stall_ready", 256'(ready), 256'(1));
                end
            end
            data  = pay[k];
            valid = 1'b1;
            step();
        end
        valid = 1'b0;
        chk("wren", 256'(wren), 256'(e_wren));
        chk("rule", 256'(rule), 256'(e_rule));
        chk("done", 256'(done), 256'(e_done));
        chk("err", 256'(err), 256'(e_err));
        chk("ready", 256'(ready), 256'(e_done ? 0 : 1));
        chk("cnt_before", 256'(cnt), 256'(m_cnt));
        if (e_done) begin
            m_rule = e_rule;
            if (m_cnt < 65535) m_cnt++;
        end
        step();
        chk("after_quiet", 256'({wren, done, err}), 256'(0));
        chk("after_cnt", 256'(cnt), 256'(m_cnt));
        chk("after_ready", 256'(ready), 256'(1));
        chk("after_rule", 256'(rule), 256'(m_rule));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 256'(ready), 256'(0));
        chk({tag, "_wren"}, 256'(wren), 256'(0));
        chk({tag, "_rule"}, 256'(rule), 256'(0));
        chk({tag, "_pulses"}, 256'({done, err}), 256'(0));
        chk({tag, "_cnt"}, 256'(cnt), 256'(0));
    endtask

    initial begin
        m_rule = '0;
        m_cnt  = 0;

        // Power-on reset
        repeat (3) step();
        chk_reset_state("rst");
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 256'(ready), 256'(0));
        step();
        chk("ready_after_edge", 256'(ready), 256'(1));

        // WRITE index 3 with 0x11111111..0x66666666
        for (int k = 0; k < NWORDS; k++) pay[k] = 32'h1111_1111 * (k + 1);
        run_cmd(32'h1000_0300, -1, 0);
        saved_rule = m_rule;
        chk("cnt_one", 256'(cnt), 256'(1));

        // CLEAR_ALL
        run_cmd(32'h3000_0000, -1, 0);

        // WRITE to out-of-range index 9 drains payload and errors
        for (int k = 0; k < NWORDS; k++) pay[k] = $urandom;
        run_cmd(32'h1000_0900, -1, 0);

        // Stalled WRITE must assemble the same rule as the unstalled one
        for (int k = 0; k < NWORDS; k++) pay[k] = 32'h1111_1111 * (k + 1);
        run_cmd(32'h1000_0300, 2, 3);
        chk("stall_same_rule", 256'(rule), 256'(saved_rule));

        // Illegal opcode and out-of-range CLEAR
        run_cmd(32'h7000_0000, -1, 0);
        run_cmd(32'h2000_0A00, -1, 0);

        // Reset in the middle of a WRITE to index 1
        data  = 32'h1000_0100;
        valid = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("abort_quiet", 256'({wren, done, err}), 256'(0));
            data = $urandom;
            step();
        end
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk_reset_state("abort_rst");
        m_rule = '0;
        m_cnt  = 0;
        repeat (2) step();
        chk_reset_state("abort_held");
        rst_n = 1'b1;
        step();
        chk("abort_release_quiet", 256'({wren, done, err}), 256'(0));
        run_cmd(32'h2000_0100, -1, 0);

        // Randomized command mix
        for (int n = 0; n < 40; n++) begin
            int         r;
            logic [3:0] op;
            logic [7:0] idx;
            int         sa;
            r   = $urandom_range(0, 9);
            if (r <= 3)      op = 4'd1;
            else if (r <= 5) op = 4'd2;
            else if (r == 6) op = 4'd3;
            else begin
                r  = $urandom_range(0, 12);
                op = (r == 0) ? 4'd0 : 4'(r + 3);
            end
            idx = 8'($urandom_range(0, 15));
            for (int k = 0; k < NWORDS; k++) pay[k] = $urandom;
            sa = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, NWORDS - 1)) : -1;
            run_cmd({op, 12'($urandom), idx, 8'($urandom)}, sa, int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
